cpi_frame_gen: RTL
==================

Name: cpi_frame_gen

Overview:
- Synthesizable CPI camera-side transmitter. Drives the pclk, hsync, vsync and data0..7 lines that the CPI receiver samples through its pad-to-CPI interface.
- Pulls pixels from a valid/ready byte stream and frames them with sync and blanking intervals set by run-time configuration.
- Used as an on-chip loopback source for CPI bring-up and as a sensor stand-in in the verification environment.

Parameters:
DATA_W, 8, pixel data width (must match CPI data0..7)
VS_W, 8, width of vsync_len_i
CNT_W, 16, width of geometry/blanking config fields

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  run enable; level, sampled in IDLE and at end of frame
clk_div_i  in  8  pclk half-period in clk_i cycles; 0 treated as 1
width_i  in  CNT_W  pixels per line minus 1
height_i  in  CNT_W  lines per frame minus 1
hblank_i  in  CNT_W  hsync-low slots after each line (0 = none)
vblank_i  in  CNT_W  slots between vsync and first line (0 = none)
vsync_len_i  in  VS_W  vsync-high slots; 0 treated as 1
pix_valid_i  in  1  stream pixel valid
pix_data_i  in  DATA_W  stream pixel
pix_ready_o  out  1  stream pop strobe
pclk_o  out  1  CPI pixel clock
hsync_o  out  1  CPI line valid, active high
vsync_o  out  1  CPI frame sync, active high
data_o  out  DATA_W  CPI pixel data
busy_o  out  1  high whenever state != IDLE
frame_done_o  out  1  one-cycle pulse at end of frame
underrun_o  out  1  sticky; cleared by reset or on leaving IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, divider and slot counters 0, shadow config 0. Reset mid-frame aborts immediately; there is no drain.
- Divider: runs only outside IDLE. cnt counts 0..D-1, where D = max(clk_div_i,1), latched into shadow. At cnt == D-1, pclk_o toggles and cnt returns to 0. pclk period = 2*D clk_i cycles.
- Slot: one pclk period. A slot boundary (fall event) is the cycle where pclk_o == 1 and cnt == D-1.
- Register updates at a fall event: state, hsync_o, vsync_o and data_o are registered and change in the same cycle pclk_o goes 0. The receiver samples on the pclk rising edge, which gives D cycles of setup and hold.
- Config shadow: all config inputs are captured on IDLE -> VSYNC and on every FRAME_END -> VSYNC. Input changes mid-frame have no effect.
- State machine:
  - IDLE: pclk_o = 0. If en_i = 1, latch shadow, clear underrun_o, and go to VSYNC on the next cycle with vsync_o = 1 and pclk_o = 0. This is the start of slot 0.
  - VSYNC: vsync_o = 1 for max(vsync_len,1) slots, then go to VBLANK, or to ACTIVE if vblank == 0.
  - VBLANK: vsync_o = 0 and hsync_o = 0 for vblank slots, then go to ACTIVE.
  - ACTIVE: hsync_o = 1 for width+1 slots, one pixel per slot.
  - HBLANK: hsync_o = 0 for hblank slots. If hblank == 0, hsync_o stays high continuously across lines; the receiver then relies on line counting.
  - ACTIVE/HBLANK sequencing: after the last slot of a line, go to HBLANK (or straight to the next ACTIVE if hblank == 0) while lines remain. After the last line, go to FRAME_END.
  - FRAME_END: entered at the fall event that ends the last line's final slot. frame_done_o pulses in that cycle. If en_i = 1, re-latch shadow and enter VSYNC in the same fall event, with no gap slot. Otherwise go to IDLE with pclk_o forced 0 and all sync/data lines 0.
- Pixel fetch:
  - In the fall-event cycle that begins an ACTIVE slot, pix_ready_o = 1 for exactly that cycle.
  - If pix_valid_i = 1, data_o <= pix_data_i.
  - Otherwise data_o <= 0 and underrun_o <= 1; the slot is still consumed and the line length is unchanged.
  - pix_ready_o is 0 at all other times. A pixel transfers only when pix_valid_i & pix_ready_o.
- Outside ACTIVE, data_o = 0.
- en_i deasserted mid-frame: the current frame completes, then IDLE.
- Slot and line counters are CNT_W bits and compare against the shadow value. Maximum line is 2^CNT_W pixels; there is no wrap hazard.

Test Plan:
- Basic frame:
  - Stimulus: div = 1, width_i = 2, height_i = 1, hblank = 2, vblank = 1, vsync_len = 1, stream always valid with bytes 0x10, 0x11, ...; en_i pulsed high for 1 cycle.
  - Required response: vsync_o high for 2 cycles, then 2 cycles low; two hsync bursts of 6 cycles each, separated by 4 low cycles; data_o sequence 10, 11, 12, 13, 14, 15 stable around pclk rising edges.
  - Also: frame_done_o pulses at cycle 24 after start, then IDLE with pclk_o = 0.
- Divider: div = 3, same geometry. Required: pclk period 6 cycles, every sync/data edge coincides with a pclk falling edge, frame_done at cycle 72.
- Underrun: pix_valid_i low for the 2nd pixel only. Required: data_o = 0 in that slot, underrun_o = 1 and sticky until the next IDLE exit, 5 pops total.
- Back-to-back frames: en_i held high with hblank = 0. Required: vsync_o of frame 2 starts in the same cycle as frame_done_o, and hsync_o stays high across both lines.
- Config change mid-frame: width_i changed from 2 to 5 during line 1. Required: the current frame keeps 3-pixel lines, the next frame uses 6.
- Mid-frame reset: rst_i asserted during ACTIVE. Required: next cycle all outputs 0, busy_o = 0, and a restart produces a clean frame.

Source files
------------

// File: rtl/cpi_frame_gen.sv
// CPI camera-side transmitter: frames a valid/ready pixel stream into
// pclk / vsync / hsync / data lines with configurable sync and blanking.
// All line outputs change together with the pclk falling edge so the
// receiver sees D clk_i cycles of setup and hold around each rising edge.
// The end-of-frame decision is taken inside the slot-boundary cycle
// itself: it either restarts VSYNC immediately or drops back to IDLE.
module cpi_frame_gen #(
  parameter int DATA_W = 8,
  parameter int VS_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [7:0]        clk_div_i,
  input  logic [CNT_W-1:0]  width_i,
  input  logic [CNT_W-1:0]  height_i,
  input  logic [CNT_W-1:0]  hblank_i,
  input  logic [CNT_W-1:0]  vblank_i,
  input  logic [VS_W-1:0]   vsync_len_i,
  input  logic              pix_valid_i,
  input  logic [DATA_W-1:0] pix_data_i,
  output logic              pix_ready_o,
  output logic              pclk_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              underrun_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBLANK = 3'd2,
    ACTIVE = 3'd3,
    HBLANK = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [VS_W-1:0]  VS_ONE  = VS_W'(1);

  state_t             state_reg, state_next;
  logic [7:0]         cnt_reg;
  logic               pclk_reg;
  logic [CNT_W-1:0]   slot_reg, line_reg;

  // configuration shadow, only refreshed at frame start
  logic [7:0]         div_sh_reg;
  logic [CNT_W-1:0]   width_sh_reg, height_sh_reg, hblank_sh_reg, vblank_sh_reg;
  logic [VS_W-1:0]    vs_sh_reg;

  logic               vsync_reg, hsync_reg, frame_done_reg, underrun_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [DATA_W-1:0]  data_fetch;

  logic               fall, slot_last, line_last;
  logic               start, frame_end, end_line, ready;

  // the slot boundary: last clk_i cycle of the high pclk phase
  assign fall      = !rst_i && (state_reg != IDLE) && pclk_reg && (cnt_reg == div_sh_reg - 8'd1);
  assign line_last = (line_reg == height_sh_reg);

  // an unaccepted pixel slot still goes out, as zero data
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fetch
    assign data_fetch[gi] = pix_valid_i & pix_data_i[gi];
  end

  // last slot of the current phase, measured against the shadow config
  always_comb begin
    slot_last = 1'b0;
    case (state_reg)
      VSYNC:   slot_last = (slot_reg == CNT_W'(vs_sh_reg - VS_ONE));
      VBLANK:  slot_last = (slot_reg == vblank_sh_reg - CNT_ONE);
      ACTIVE:  slot_last = (slot_reg == width_sh_reg);
      HBLANK:  slot_last = (slot_reg == hblank_sh_reg - CNT_ONE);
      default: slot_last = 1'b0;
    endcase
  end

  // next-state logic; end-of-line and end-of-frame resolved in the same cycle
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    frame_end  = 1'b0;
    end_line   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en_i) begin
          state_next = VSYNC;
          start      = 1'b1;
        end
      end
      VSYNC: begin
        if (fall && slot_last) state_next = (vblank_sh_reg != '0) ? VBLANK : ACTIVE;
      end
      VBLANK: begin
        if (fall && slot_last) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (fall && slot_last) begin
          if (hblank_sh_reg != '0) state_next = HBLANK;
          else                     end_line   = 1'b1;
        end
      end
      HBLANK: begin
        if (fall && slot_last) end_line = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (end_line) begin
      if (!line_last) begin
        state_next = ACTIVE;
      end else begin
        frame_end = 1'b1;
        if (en_i) begin
          state_next = VSYNC;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
    end
    ready = fall && (state_next == ACTIVE);
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // pclk divider: idle-low, restarted from phase 0 at every frame start
  always_ff @(posedge clk_i) begin
    if (rst_i || start || state_next == IDLE) begin
      cnt_reg  <= 8'd0;
      pclk_reg <= 1'b0;
    end else if (cnt_reg == div_sh_reg - 8'd1) begin
      cnt_reg  <= 8'd0;
      pclk_reg <= ~pclk_reg;
    end else begin
      cnt_reg  <= cnt_reg + 8'd1;
    end
  end

  // config shadow capture; zero divider and vsync length mean one
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_sh_reg    <= 8'd0;
      width_sh_reg  <= '0;
      height_sh_reg <= '0;
      hblank_sh_reg <= '0;
      vblank_sh_reg <= '0;
      vs_sh_reg     <= '0;
    end else if (start) begin
      div_sh_reg    <= (clk_div_i == 8'd0) ? 8'd1 : clk_div_i;
      width_sh_reg  <= width_i;
      height_sh_reg <= height_i;
      hblank_sh_reg <= hblank_i;
      vblank_sh_reg <= vblank_i;
      vs_sh_reg     <= (vsync_len_i == '0) ? VS_ONE : vsync_len_i;
    end
  end

  // slot and line counters, advanced at slot boundaries
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_reg <= '0;
      line_reg <= '0;
    end else if (start) begin
      slot_reg <= '0;
      line_reg <= '0;
    end else if (fall) begin
      slot_reg <= slot_last ? '0 : slot_reg + CNT_ONE;
      if (end_line && !line_last) line_reg <= line_reg + CNT_ONE;
    end
  end

  // CPI line registers and status flags, updated with the pclk falling edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_reg      <= 1'b0;
      hsync_reg      <= 1'b0;
      data_reg       <= '0;
      frame_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      frame_done_reg <= frame_end;
      if (start && state_reg == IDLE) underrun_reg <= 1'b0;
      if (start || fall) begin
        vsync_reg <= (state_next == VSYNC);
        hsync_reg <= (state_next == ACTIVE);
        data_reg  <= ready ? data_fetch : '0;
        if (ready && !pix_valid_i) underrun_reg <= 1'b1;
      end
    end
  end

  assign pix_ready_o  = ready;
  assign pclk_o       = pclk_reg;
  assign hsync_o      = hsync_reg;
  assign vsync_o      = vsync_reg;
  assign data_o       = data_reg;
  assign busy_o       = (state_reg != IDLE);
  assign frame_done_o = frame_done_reg;
  assign underrun_o   = underrun_reg;

endmodule
